bcd_increment_sequencer: RTL and testbench

Multi-digit BCD counter core that sits downstream of the input debounce/trigger stage. It accepts a one-cycle start pulse plus a mask of pressed digit buttons. It then walks the digits LSD to MSD, one per clock, adding 1 to each selected digit and rippling the carry. On completion it emits a one-cycle `done` pulse that the display path uses as its refresh trigger. Sequencing the carry explicitly gives a fixed, known latency and removes the fixed wait-for-carry delay from the trigger stage.

---
 rtl/bcd_increment_sequencer.sv | 128 ++++++++++++
 tb/tb_bcd_increment_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_increment_sequencer.sv
// Multi-digit BCD counter: adds a per-digit mask to the count one digit per clock,
// LSD first, rippling the decimal carry, then pulses done (and overflow on wrap).
module bcd_increment_sequencer #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIGITS-1:0]     sel,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic                carry_reg, carry_next;
    logic [DIGITS-1:0]   pend_reg, pend_next;
    logic                ovf_flag_reg, ovf_flag_next;
    logic [4*DIGITS-1:0] count_reg, count_next;
    logic                busy_reg, done_reg, overflow_reg;

    logic [DIGITS-1:0]   digit_hit;
    logic [DIGITS-1:0]   digit_cout;
    logic                scan_cout;

    // One adder per digit; only the digit currently addressed by idx is written back.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [4:0] sum;

            assign digit_hit[gi]  = (state_reg == SCAN) && (idx_reg == IDX_W'(gi));
            assign sum            = {1'b0, count_reg[4*gi +: 4]}
                                  + {4'd0, pend_reg[gi]}
                                  + {4'd0, carry_reg};
            assign digit_cout[gi] = (sum >= 5'd10);
            assign count_next[4*gi +: 4] = !digit_hit[gi]  ? count_reg[4*gi +: 4] :
                                           digit_cout[gi]  ? (sum[3:0] - 4'd10)   :
                                                             sum[3:0];
        end
    endgenerate

    assign scan_cout = |(digit_hit & digit_cout);

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        carry_next    = carry_reg;
        pend_next     = pend_reg;
        ovf_flag_next = ovf_flag_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    pend_next  = sel;
                    carry_next = 1'b0;
                    idx_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                carry_next = scan_cout;
                if (idx_reg == LAST_IDX) begin
                    ovf_flag_next = scan_cout;
                    state_next    = DONE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over everything, including a start sampled in the same cycle.
        if (clear) begin
            state_next = IDLE;
            idx_next   = '0;
            carry_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            pend_reg     <= '0;
            ovf_flag_reg <= 1'b0;
            count_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            carry_reg    <= carry_next;
            pend_reg     <= pend_next;
            ovf_flag_reg <= ovf_flag_next;
            count_reg    <= clear ? '0 : count_next;
            // Status flags trail the state register by one clock, so done lands
            // after the DONE cycle and busy covers the whole scan plus done.
            busy_reg     <= !clear && (state_reg != IDLE);
            done_reg     <= !clear && (state_reg == DONE);
            overflow_reg <= !clear && (state_reg == DONE) && ovf_flag_reg;
        end
    end

    assign count_bcd = count_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_bcd_increment_sequencer.sv
// Bench for bcd_increment_sequencer: table of mask additions plus hand-written
// abort, reset and back-to-back sequences, checked through an expected-result queue.
module tb_bcd_increment_sequencer;
    localparam int DIGITS = 6;

    logic                clk;
    logic                reset;
    logic                start;
    logic [DIGITS-1:0]   sel;
    logic                clear;
    logic [4*DIGITS-1:0] count_bcd;
    logic                busy;
    logic                done;
    logic                overflow;

    bcd_increment_sequencer #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sel       (sel),
        .clear     (clear),
        .count_bcd (count_bcd),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] cnt;
        logic        ovf;
    } exp_t;

    typedef struct {
        bit          clr;
        logic [5:0]  sel;
        int          rep;
        logic [23:0] cnt;
        bit          ovf;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   total = 0;
    int   bad = 0;
    int   done_count = 0;
    int   model_val = 0;
    logic last_ovf = 1'b0;
    int   base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference: the mask is a plain integer sum of powers of ten.
    task automatic push_expect(input logic [5:0] s);
        int add;
        int p;
        int nv;
        exp_t e;
        add = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[i]) add += p;
            p *= 10;
        end
        nv = model_val + add;
        e.ovf = (nv >= 1000000);
        model_val = nv % 1000000;
        e.cnt = to_bcd(model_val);
        exp_q.push_back(e);
    endtask

    // Starts one request and checks the busy/done waveform cycle by cycle.
    task automatic run_op(input logic [5:0] s);
        start = 1'b1;
        sel = s;
        push_expect(s);
        tick();
        start = 1'b0;
        sel = '0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            check($sformatf("busy_k%0d", k), 32'(busy), 32'(k >= 1 && k <= 7));
            check($sformatf("done_k%0d", k), 32'(done), 32'(k == 7));
            if (done) last_ovf = overflow;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_val = 0;
        check("clear_count", 32'(count_bcd), 32'h0);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            $display("done #%0d count=%06h ovf=%0b", done_count, count_bcd, overflow);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got count %06h want no done", count_bcd);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_count", 32'(count_bcd), 32'(mon_e.cnt));
                check("sb_ovf", 32'(overflow), 32'(mon_e.ovf));
            end
        end else if (overflow === 1'b1) begin
            total++;
            bad++;
            $display("FAIL ovf_without_done: got 1 want 0");
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        sel = '0;

        vecs[0] = '{1'b1, 6'b000001, 1, 24'h000001, 1'b0};
        vecs[1] = '{1'b1, 6'b000011, 9, 24'h000099, 1'b0};
        vecs[2] = '{1'b0, 6'b000011, 1, 24'h000110, 1'b0};
        vecs[3] = '{1'b1, 6'b111111, 9, 24'h999999, 1'b0};
        vecs[4] = '{1'b0, 6'b000001, 1, 24'h000000, 1'b1};
        vecs[5] = '{1'b0, 6'b000000, 1, 24'h000000, 1'b0};
        vecs[6] = '{1'b1, 6'b100000, 1, 24'h100000, 1'b0};
        vecs[7] = '{1'b0, 6'b101010, 3, 24'h403030, 1'b0};
        vecs[8] = '{1'b0, 6'b111111, 6, 24'h069696, 1'b1};

        repeat (3) tick();
        reset = 1'b0;
        check("rst_count", 32'(count_bcd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].clr) pulse_clear();
            for (int r = 0; r < vecs[v].rep; r++) run_op(vecs[v].sel);
            check($sformatf("vec%0d_count", v), 32'(count_bcd), 32'(vecs[v].cnt));
            check($sformatf("vec%0d_ovf", v), 32'(last_ovf), 32'(vecs[v].ovf));
        end

        // Starts during a running sequence are dropped; one on the edge busy falls is taken.
        pulse_clear();
        base = done_count;
        start = 1'b1; sel = 6'b000001; push_expect(6'b000001);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; sel = 6'b111111;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; sel = 6'b000010; push_expect(6'b000010);
        tick();
        start = 1'b0; sel = '0;
        check("b2b_busy_fell", 32'(busy), 32'h0);
        repeat (10) tick();
        check("b2b_done_pulses", 32'(done_count - base), 32'd2);
        check("b2b_count", 32'(count_bcd), 32'h000011);

        // Clear while digit 3 is being processed.
        start = 1'b1; sel = 6'b000001;
        tick();
        start = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_val = 0;
        check("abort_count", 32'(count_bcd), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        base = done_count;
        repeat (10) tick();
        check("abort_no_done", 32'(done_count - base), 32'd0);

        // Reset mid-scan together with a start request.
        run_op(6'b000101);
        start = 1'b1; sel = 6'b111111;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        model_val = 0;
        check("mid_rst_count", 32'(count_bcd), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_ovf", 32'(overflow), 32'h0);
        repeat (3) tick();
        check("mid_rst_start_dropped", 32'(busy), 32'h0);
        run_op(6'b100000);
        check("post_rst_count", 32'(count_bcd), 32'h100000);

        repeat (5) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
